// File: rtl/inst_cache_assoc.sv
// Set-associative instruction cache with burst line refill, round-robin replacement and cancellable misses.
// Optional performance counters are enabled by defining INST_CACHE_PERF_EN.
//
// state     | meaning
// ST_IDLE   | lookups compared against tags; a miss latches the line and starts refill
// ST_REFILL | one RAM word requested per InstReady until the line is full
// ST_DONE   | tag/valid written, set pointer advanced, completion pulse driven
module inst_cache_assoc #(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int HARTS      = 4,
    parameter int HART_W     = (HARTS > 1) ? $clog2(HARTS) : 1
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              Enable,
    input  logic [31:0]       Address,
    input  logic [HART_W-1:0] mhartID_ID,
    input  logic              flush,
    input  logic              Ignore,
    output logic [31:0]       I,
    output logic              InstHit,
    output logic              InstMiss,
    output logic              Busy,
    output logic [31:0]       FetchingAddress,
    output logic [HART_W-1:0] FetchingmhartID,
    output logic              InstRead,
    output logic [31:0]       InstAddress,
    input  logic [31:0]       InstfromRam,
    input  logic              InstReady,
    output logic              DoneRetrieving,
    output logic [HART_W-1:0] RetrievingDoneFor,
    output logic              IgnoreMiss
`ifdef INST_CACHE_PERF_EN
    ,
    input  logic              PerfClear,
    output logic [31:0]       HitCount,
    output logic [31:0]       MissCount,
    output logic [31:0]       CancelCount
`endif
);

    localparam int OFF_BITS = $clog2(LINE_WORDS);
    localparam int IDX_BITS = $clog2(SETS);
    localparam int OFF_W    = (OFF_BITS > 0) ? OFF_BITS : 1;
    localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int DAT_BITS = $clog2(SETS * LINE_WORDS);
    localparam int DAT_W    = (DAT_BITS > 0) ? DAT_BITS : 1;
    localparam int TAG_LSB  = 2 + OFF_BITS + IDX_BITS;
    localparam int TAG_W    = 32 - TAG_LSB;
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_REFILL, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic                lookup_vld_q, lookup_vld_d;
    logic [31:0]         fetch_addr_q, fetch_addr_d;
    logic [HART_W-1:0]   fetch_hart_q, fetch_hart_d;
    logic [31:0]         line_base_q, line_base_d;
    logic [IDX_W-1:0]    set_q, set_d;
    logic [HART_W-1:0]   owner_q, owner_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic [OFF_W-1:0]    wcnt_q, wcnt_d;
    logic                cancel_q, cancel_d;
    logic                flush_pend_q, flush_pend_d;
    logic [SETS-1:0]     valid_q [WAYS];
    logic [SETS-1:0]     valid_d [WAYS];
    logic [WAY_W-1:0]    rr_q [SETS];
    logic [WAY_W-1:0]    rr_d [SETS];

    logic [TAG_W-1:0]    tag_mem  [WAYS][SETS];
    logic [31:0]         data_mem [WAYS][SETS*LINE_WORDS];

    logic [IDX_W-1:0]    lk_idx;
    logic [OFF_W-1:0]    lk_off;
    logic [TAG_W-1:0]    lk_tag;
    logic                hit_any;
    logic [WAY_W-1:0]    hit_way;
    logic [31:0]         hit_word;
    logic                lookup_hit, lookup_miss;
    logic                dat_we, tag_we;
    logic [DAT_W-1:0]    dat_wr_idx;

    assign lk_idx = IDX_W'((fetch_addr_q >> (2 + OFF_BITS)) & 32'(SETS - 1));
    assign lk_off = OFF_W'((fetch_addr_q >> 2) & 32'(LINE_WORDS - 1));
    assign lk_tag = TAG_W'(fetch_addr_q >> TAG_LSB);

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][lk_idx] && (tag_mem[w][lk_idx] == lk_tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit_word    = data_mem[hit_way][DAT_W'(int'(lk_idx) * LINE_WORDS + int'(lk_off))];
    // A same-cycle flush invalidates everything before the compare can hit.
    assign lookup_hit  = (state_q == ST_IDLE) && lookup_vld_q && !flush && hit_any;
    assign lookup_miss = (state_q == ST_IDLE) && lookup_vld_q && !lookup_hit;
    assign dat_wr_idx  = DAT_W'(int'(set_q) * LINE_WORDS + int'(wcnt_q));

    assign I                 = lookup_hit ? hit_word : 32'd0;
    assign InstHit           = lookup_hit;
    assign InstMiss          = lookup_miss;
    assign Busy              = (state_q != ST_IDLE);
    assign InstRead          = (state_q == ST_REFILL);
    assign InstAddress       = (state_q == ST_REFILL) ? (line_base_q + (32'(wcnt_q) << 2)) : 32'd0;
    assign FetchingAddress   = fetch_addr_q;
    assign FetchingmhartID   = fetch_hart_q;
    assign DoneRetrieving    = (state_q == ST_DONE) && !cancel_q;
    assign IgnoreMiss        = (state_q == ST_DONE) && cancel_q;
    assign RetrievingDoneFor = (state_q == ST_DONE) ? owner_q : '0;

    always_comb begin
        state_d      = state_q;
        lookup_vld_d = Enable;
        fetch_addr_d = fetch_addr_q;
        fetch_hart_d = fetch_hart_q;
        line_base_d  = line_base_q;
        set_d        = set_q;
        owner_d      = owner_q;
        victim_d     = victim_q;
        wcnt_d       = wcnt_q;
        cancel_d     = cancel_q;
        flush_pend_d = flush_pend_q;
        valid_d      = valid_q;
        rr_d         = rr_q;
        dat_we       = 1'b0;
        tag_we       = 1'b0;

        if (Enable) begin
            fetch_addr_d = Address;
            fetch_hart_d = mhartID_ID;
        end

        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    for (int w = 0; w < WAYS; w++) valid_d[w] = '0;
                end
                if (lookup_miss) begin
                    line_base_d  = fetch_addr_q & LINE_MASK;
                    set_d        = lk_idx;
                    owner_d      = fetch_hart_q;
                    victim_d     = rr_q[lk_idx];
                    wcnt_d       = '0;
                    cancel_d     = 1'b0;
                    flush_pend_d = 1'b0;
                    // The victim is overwritten word by word, so it stops being a valid line now.
                    valid_d[rr_q[lk_idx]][lk_idx] = 1'b0;
                    state_d      = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (Ignore) cancel_d = 1'b1;
                if (flush)  flush_pend_d = 1'b1;
                if (InstReady) begin
                    dat_we = 1'b1;
                    if (wcnt_q == LAST_WORD) state_d = ST_DONE;
                    else                     wcnt_d  = wcnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                tag_we = 1'b1;
                if (flush_pend_q || flush) begin
                    for (int w = 0; w < WAYS; w++) valid_d[w] = '0;
                end else begin
                    valid_d[victim_q][set_q] = 1'b1;
                end
                rr_d[set_q] = (WAYS == 1) ? '0 : victim_q + 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= ST_IDLE;
            lookup_vld_q <= 1'b0;
            fetch_addr_q <= '0;
            fetch_hart_q <= '0;
            line_base_q  <= '0;
            set_q        <= '0;
            owner_q      <= '0;
            victim_q     <= '0;
            wcnt_q       <= '0;
            cancel_q     <= 1'b0;
            flush_pend_q <= 1'b0;
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            state_q      <= state_d;
            lookup_vld_q <= lookup_vld_d;
            fetch_addr_q <= fetch_addr_d;
            fetch_hart_q <= fetch_hart_d;
            line_base_q  <= line_base_d;
            set_q        <= set_d;
            owner_q      <= owner_d;
            victim_q     <= victim_d;
            wcnt_q       <= wcnt_d;
            cancel_q     <= cancel_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            rr_q         <= rr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (dat_we) data_mem[victim_q][dat_wr_idx] <= InstfromRam;
        if (tag_we) tag_mem[victim_q][set_q]       <= TAG_W'(line_base_q >> TAG_LSB);
    end

`ifdef INST_CACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic [31:0] cancel_cnt_q, cancel_cnt_d;

    always_comb begin
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        cancel_cnt_d = cancel_cnt_q;
        if (InstHit && (hit_cnt_q != '1))       hit_cnt_d    = hit_cnt_q + 32'd1;
        if (InstMiss && (miss_cnt_q != '1))     miss_cnt_d   = miss_cnt_q + 32'd1;
        if (IgnoreMiss && (cancel_cnt_q != '1)) cancel_cnt_d = cancel_cnt_q + 32'd1;
        if (PerfClear) begin
            hit_cnt_d    = '0;
            miss_cnt_d   = '0;
            cancel_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            cancel_cnt_q <= '0;
        end else begin
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            cancel_cnt_q <= cancel_cnt_d;
        end
    end

    assign HitCount    = hit_cnt_q;
    assign MissCount   = miss_cnt_q;
    assign CancelCount = cancel_cnt_q;
`endif

endmodule
